// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter for the common data bus (CDB) of an out-of-order core.
//   Four execution units offer one completed result each (0 add/sub, 1 mul,
//   2 div, 3 load/store). At most one result is granted per cycle. The granted
//   tag/value are broadcast on the CDB one cycle later, for exactly one cycle.
//
// Ports
//   clk          : single clock, rising-edge active
//   rst          : synchronous active-high reset
//   req_valid    : per-unit result pending
//   req_tag      : per-unit ROB tag, unit i at [i*TAG_W +: TAG_W]
//   req_value    : per-unit result, unit i at [i*DATA_W +: DATA_W]
//   req_ready    : one-hot grant (combinational)
//   flush        : squash from the ROB; blocks grants and kills the broadcast
//   cdb_valid    : broadcast valid
//   cdb_tag      : broadcast ROB tag
//   cdb_value    : broadcast result
//   cdb_src      : index of the unit being broadcast
//   bcast_count  : running count of completed transfers (wraps)
module cdb_arbiter #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req_valid,
  input  logic [4*TAG_W-1:0]    req_tag,
  input  logic [4*DATA_W-1:0]   req_value,
  output logic [3:0]            req_ready,
  input  logic                  flush,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [DATA_W-1:0]     cdb_value,
  output logic [1:0]            cdb_src,
  output logic [15:0]           bcast_count
);

  // Search order starts at ptr and wraps modulo 4. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] valid);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      // Walk from the farthest candidate back to ptr so the nearest one wins.
      idx = ptr + 2'(k);
      if (valid[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [1:0]        cdb_src_q, cdb_src_d;
  logic [15:0]       bcast_count_q, bcast_count_d;

  logic [2:0]        pick_s;
  logic [1:0]        win_s;
  logic              xfer_s;
  logic [3:0]        grant_s;

  // Arbitration: pick the winner and form the one-hot grant.
  always_comb begin
    pick_s  = rr_pick(rr_ptr_q, req_valid);
    win_s   = pick_s[1:0];
    grant_s = 4'b0000;
    // Reset and flush both suppress the grant so nothing is consumed.
    if (pick_s[2] && !rst && !flush) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = 4'b0000;
    end
    xfer_s = |grant_s;
  end

  assign req_ready = grant_s;

  // Next-state: capture the winner on a transfer, otherwise hold the payload.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    cdb_valid_d   = 1'b0;
    cdb_tag_d     = cdb_tag_q;
    cdb_value_d   = cdb_value_q;
    cdb_src_d     = cdb_src_q;
    bcast_count_d = bcast_count_q;
    if (xfer_s) begin
      rr_ptr_d      = win_s + 2'd1;
      cdb_valid_d   = 1'b1;
      cdb_tag_d     = req_tag[int'(win_s)*TAG_W +: TAG_W];
      cdb_value_d   = req_value[int'(win_s)*DATA_W +: DATA_W];
      cdb_src_d     = win_s;
      bcast_count_d = bcast_count_q + 16'd1;
    end else begin
      rr_ptr_d      = rr_ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= 2'd0;
      cdb_valid_q   <= 1'b0;
      cdb_tag_q     <= '0;
      cdb_value_q   <= '0;
      cdb_src_q     <= 2'd0;
      bcast_count_q <= 16'd0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_value_q   <= cdb_value_d;
      cdb_src_q     <= cdb_src_d;
      bcast_count_q <= bcast_count_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_src     = cdb_src_q;
  assign bcast_count = bcast_count_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_W, default 3, meaning ROB tag width (8-entry ROB).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning result value width (1-byte registers).
REQ-003 The block SHALL have a fixed requester count of 4: index 0 add/sub, 1 mul, 2 div, 3 load/store.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 4 bits: per-unit result pending.
REQ-007 The block SHALL have port req_tag, input, 4*TAG_W bits: per-unit ROB tag, unit i at bits [i*TAG_W +: TAG_W].
REQ-008 The block SHALL have port req_value, input, 4*DATA_W bits: per-unit result, unit i at bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port req_ready, output, 4 bits: one-hot grant, combinational.
REQ-010 The block SHALL have port flush, input, 1 bit: mispredict/exception squash from ROB.
REQ-011 The block SHALL have port cdb_valid, output, 1 bit: broadcast valid.
REQ-012 The block SHALL have port cdb_tag, output, TAG_W bits: broadcast ROB tag.
REQ-013 The block SHALL have port cdb_value, output, DATA_W bits: broadcast result.
REQ-014 The block SHALL have port cdb_src, output, 2 bits: index of the unit that won.
REQ-015 The block SHALL have port bcast_count, output, 16 bits: total completed broadcasts.

Function
REQ-016 The block SHALL hold a 2-bit round-robin pointer rr_ptr.
REQ-017 Each cycle, the block SHALL select the first asserted req_valid, searching indices rr_ptr, rr_ptr+1, ... modulo 4.
REQ-018 req_ready SHALL be one-hot at the selected index, or all-zero when there is no request, flush=1, or rst=1.
REQ-019 A transfer SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-020 A unit not granted SHALL keep its valid, tag and value stable; the arbiter relies on this and does not sample them.
REQ-021 On a transfer from unit i, at the next edge: cdb_valid<=1, cdb_tag<=tag i, cdb_value<=value i, cdb_src<=i, rr_ptr<=(i+1) mod 4.
REQ-022 Latency from transfer to broadcast SHALL be exactly 1 cycle.
REQ-023 Every broadcast SHALL last exactly 1 cycle; back-to-back transfers SHALL produce a broadcast every cycle, so throughput is 1 per cycle.
REQ-024 With no transfer, at the next edge cdb_valid<=0 and rr_ptr is unchanged; cdb_tag, cdb_value and cdb_src hold their last values.
REQ-025 flush=1 SHALL block grants that cycle and force cdb_valid<=0 at the next edge, even if a broadcast was already pending; rr_ptr and bcast_count are unchanged.
REQ-026 bcast_count SHALL increment by 1 on each transfer, wrapping 0xFFFF to 0x0000.
REQ-027 Pointer wrap: a grant to unit 3 SHALL set rr_ptr to 0.
REQ-028 Fairness: a continuously asserted request SHALL be granted within 4 cycles.

Reset
REQ-029 With rst=1 at an edge, the block SHALL set rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0, bcast_count=0.
REQ-030 rst SHALL take priority over flush and any request; a request present during reset is not granted and is not lost (the unit keeps it asserted).
REQ-031 On the first cycle after rst deasserts, priority SHALL start at unit 0.

Verification
REQ-032 After reset, req_valid=4'b1111 held for 4 cycles -> grants in order 0,1,2,3; cdb_src is 0,1,2,3 on cycles 1-4; bcast_count=4.
REQ-033 Only unit 2 valid, tag=3'd5, value=8'hA7 -> req_ready=4'b0100 the same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_value=A7, cdb_src=2, rr_ptr=3.
REQ-034 rr_ptr=3 and req_valid=4'b0011 -> unit 0 granted (wrap), then unit 1 the next cycle.
REQ-035 Grant to unit 1 with flush=1 in the same cycle -> req_ready=0 and cdb_valid=0 next cycle; bcast_count unchanged; unit 1 is granted after flush drops.
REQ-036 bcast_count preloaded to 0xFFFF by running 65535 transfers, then one more transfer -> 0x0000.
REQ-037 rst=1 asserted while cdb_valid=1 and requests are pending -> next cycle all outputs are 0 and req_ready=0; after release, the first grant goes to the lowest pending index.
